powerup_scheduler: RTL and testbench

Sequences the power-pack resource on the Pong playfield. It decides when a pack spawns and where, picks its mode, and withdraws the pack when its lifetime ends. When a pack is eaten it arbitrates between the two players, then runs each player's effect timer. It sits between the game-logic top level, which supplies the frame tick and the eaten/collision pulses, and the power-pack drawing block, which consumes spawn, randx, randy and mode.

---
 rtl/powerup_scheduler.sv | 187 ++++++++++++++++++
 tb/tb_powerup_scheduler.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/powerup_scheduler.sv
// rtl/powerup_scheduler.sv - power-pack spawn/lifetime sequencer with per-player effect timers
module powerup_scheduler #(
  parameter int          COOLDOWN_FRAMES = 120,
  parameter int          LIFETIME_FRAMES = 600,
  parameter int          EFFECT_FRAMES   = 300,
  parameter int          X_MIN           = 64,
  parameter int          X_SPAN          = 896,
  parameter int          Y_MIN           = 48,
  parameter int          Y_SPAN          = 672,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic        enable,
  input  logic        eaten_p1,
  input  logic        eaten_p2,
  output logic        spawn,
  output logic        eaten,
  output logic [10:0] randx,
  output logic [9:0]  randy,
  output logic [1:0]  mode,
  output logic        pack_live,
  output logic        fx_p1_active,
  output logic        fx_p2_active,
  output logic [1:0]  fx_p1_mode,
  output logic [1:0]  fx_p2_mode
);

  typedef enum logic [1:0] {S_IDLE, S_SPAWN, S_LIVE, S_GRANT} state_t;

  state_t      state, state_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic [15:0] lfsr;
  logic [15:0] fx_p1_timer, fx_p2_timer;
  logic        prio_p2;
  logic        win_p2;
  logic        tick;
  logic        start_spawn, start_grant, expire, go_live, finish_grant;
  logic [10:0] raw_x, x_off, x_pos;
  logic [9:0]  raw_y, y_off, y_pos;
  logic [1:0]  mode_pos;

  assign tick = frame_tick & enable;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) lfsr <= LFSR_SEED;
    else        lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  // Spans are at least half the raw range, so one conditional subtract folds it in.
  always_comb begin
    raw_x    = {1'b0, lfsr[9:0]};
    x_off    = (raw_x >= 11'(X_SPAN)) ? raw_x - 11'(X_SPAN) : raw_x;
    x_pos    = 11'(X_MIN) + x_off;
    raw_y    = {1'b0, lfsr[15:7]};
    y_off    = (raw_y >= 10'(Y_SPAN)) ? raw_y - 10'(Y_SPAN) : raw_y;
    y_pos    = 10'(Y_MIN) + y_off;
    mode_pos = (lfsr[1:0] == 2'b10) ? 2'b01 : lfsr[1:0];
  end

  // cnt counts elapsed ticks from state entry, so its reset value of 0 is the IDLE entry value.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    start_spawn  = 1'b0;
    start_grant  = 1'b0;
    expire       = 1'b0;
    go_live      = 1'b0;
    finish_grant = 1'b0;
    if (enable) begin
      case (state)
        S_IDLE: begin
          if (frame_tick) begin
            if (cnt == 16'(COOLDOWN_FRAMES - 1)) begin
              state_nxt   = S_SPAWN;
              cnt_nxt     = '0;
              start_spawn = 1'b1;
            end else begin
              cnt_nxt = cnt + 16'd1;
            end
          end
        end
        S_SPAWN: begin
          state_nxt = S_LIVE;
          cnt_nxt   = '0;
          go_live   = 1'b1;
        end
        S_LIVE: begin
          if (eaten_p1 || eaten_p2) begin
            state_nxt   = S_GRANT;
            cnt_nxt     = '0;
            start_grant = 1'b1;
          end else if (frame_tick) begin
            if (cnt == 16'(LIFETIME_FRAMES - 1)) begin
              state_nxt = S_IDLE;
              cnt_nxt   = '0;
              expire    = 1'b1;
            end else begin
              cnt_nxt = cnt + 16'd1;
            end
          end
        end
        S_GRANT: begin
          state_nxt    = S_IDLE;
          cnt_nxt      = '0;
          finish_grant = 1'b1;
        end
        default: begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      spawn     <= 1'b0;
      eaten     <= 1'b0;
      pack_live <= 1'b0;
      randx     <= '0;
      randy     <= '0;
      mode      <= '0;
      prio_p2   <= 1'b0;
      win_p2    <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      spawn <= start_spawn;
      eaten <= start_grant | expire;
      // Position is captured on entry to SPAWN so it is stable for the whole spawn pulse.
      if (start_spawn) begin
        randx <= x_pos;
        randy <= y_pos;
        mode  <= mode_pos;
      end
      if (go_live)                   pack_live <= 1'b1;
      else if (start_grant | expire) pack_live <= 1'b0;
      if (start_grant) begin
        win_p2 <= eaten_p2 & (~eaten_p1 | prio_p2);
        if (eaten_p1 && eaten_p2) prio_p2 <= ~prio_p2;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fx_p1_active <= 1'b0;
      fx_p1_mode   <= '0;
      fx_p1_timer  <= '0;
    end else if (finish_grant && !win_p2) begin
      fx_p1_active <= 1'b1;
      fx_p1_mode   <= mode;
      fx_p1_timer  <= 16'(EFFECT_FRAMES - 1);
    end else if (fx_p1_active && tick) begin
      if (fx_p1_timer == '0) begin
        fx_p1_active <= 1'b0;
        fx_p1_mode   <= '0;
      end else begin
        fx_p1_timer <= fx_p1_timer - 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fx_p2_active <= 1'b0;
      fx_p2_mode   <= '0;
      fx_p2_timer  <= '0;
    end else if (finish_grant && win_p2) begin
      fx_p2_active <= 1'b1;
      fx_p2_mode   <= mode;
      fx_p2_timer  <= 16'(EFFECT_FRAMES - 1);
    end else if (fx_p2_active && tick) begin
      if (fx_p2_timer == '0) begin
        fx_p2_active <= 1'b0;
        fx_p2_mode   <= '0;
      end else begin
        fx_p2_timer <= fx_p2_timer - 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_powerup_scheduler.sv
// tb/tb_powerup_scheduler.sv - scoreboard bench for powerup_scheduler
module tb_powerup_scheduler;

  localparam int X_MIN  = 64;
  localparam int X_SPAN = 896;
  localparam int Y_MIN  = 48;
  localparam int Y_SPAN = 400;

  typedef enum int {EV_SPAWN, EV_WITHDRAW, EV_GRANT1, EV_GRANT2} ev_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        frame_tick = 1'b0;
  logic        enable = 1'b0;
  logic        eaten_p1 = 1'b0;
  logic        eaten_p2 = 1'b0;
  logic        spawn, eaten, pack_live;
  logic [10:0] randx;
  logic [9:0]  randy;
  logic [1:0]  mode, fx_p1_mode, fx_p2_mode;
  logic        fx_p1_active, fx_p2_active;

  int          n_tests = 0;
  int          n_fail = 0;
  ev_t         sb[$];
  ev_t         exp_ev;
  ev_t         last_ev = EV_SPAWN;
  logic        prev_spawn = 1'b0;
  logic        prev_eaten = 1'b0;
  logic [1:0]  pack_mode_m = 2'b00;
  logic [15:0] lfsr_m, lfsr_prev;

  powerup_scheduler #(
    .COOLDOWN_FRAMES(2), .LIFETIME_FRAMES(3), .EFFECT_FRAMES(2),
    .X_MIN(X_MIN), .X_SPAN(X_SPAN), .Y_MIN(Y_MIN), .Y_SPAN(Y_SPAN),
    .LFSR_SEED(16'hACE1)
  ) dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .enable(enable),
    .eaten_p1(eaten_p1), .eaten_p2(eaten_p2), .spawn(spawn), .eaten(eaten),
    .randx(randx), .randy(randy), .mode(mode), .pack_live(pack_live),
    .fx_p1_active(fx_p1_active), .fx_p2_active(fx_p2_active),
    .fx_p1_mode(fx_p1_mode), .fx_p2_mode(fx_p2_mode)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
    end
  endtask

  // Reference sequence: 16-bit Fibonacci LFSR, taps 16,14,13,11, stepping every clock.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr_m    <= 16'hACE1;
      lfsr_prev <= 16'hACE1;
    end else begin
      lfsr_prev <= lfsr_m;
      lfsr_m    <= {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
    end
  end

  always @(negedge clk) begin
    int ex, ey;
    logic [1:0] em;
    if (!reset) begin
      prev_spawn = 1'b0;
      prev_eaten = 1'b0;
    end else begin
      if (prev_spawn) check_eq("live_after_spawn", 32'(pack_live), 32'd1);
      if (prev_eaten && last_ev == EV_GRANT1) begin
        check_eq("grant_p1_active", 32'(fx_p1_active), 32'd1);
        check_eq("grant_p1_mode", 32'(fx_p1_mode), 32'(pack_mode_m));
      end
      if (prev_eaten && last_ev == EV_GRANT2) begin
        check_eq("grant_p2_active", 32'(fx_p2_active), 32'd1);
        check_eq("grant_p2_mode", 32'(fx_p2_mode), 32'(pack_mode_m));
      end
      if (spawn || eaten) begin
        check_eq("pulse_exclusive", 32'(spawn & eaten), 32'd0);
        if (sb.size() == 0) begin
          check_eq("unexpected_pulse", 32'({spawn, eaten}), 32'd0);
        end else begin
          exp_ev = sb.pop_front();
          last_ev = exp_ev;
          if (spawn) begin
            check_eq("event_is_spawn", 32'(exp_ev == EV_SPAWN), 32'd1);
            ex = X_MIN + (int'(lfsr_prev[9:0]) % X_SPAN);
            ey = Y_MIN + (int'(lfsr_prev[15:7]) % Y_SPAN);
            em = (lfsr_prev[1:0] == 2'b10) ? 2'b01 : lfsr_prev[1:0];
            check_eq("randx", 32'(randx), 32'(ex));
            check_eq("randy", 32'(randy), 32'(ey));
            check_eq("mode", 32'(mode), 32'(em));
            pack_mode_m = em;
          end else begin
            check_eq("event_is_eaten", 32'(exp_ev != EV_SPAWN), 32'd1);
            check_eq("live_at_eaten", 32'(pack_live), 32'd0);
          end
        end
      end
      prev_spawn = spawn;
      prev_eaten = eaten;
    end
  end

  task automatic do_tick();
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic do_eat(input logic a, input logic b);
    @(negedge clk) begin eaten_p1 = a; eaten_p2 = b; end
    @(negedge clk) begin eaten_p1 = 1'b0; eaten_p2 = 1'b0; end
    repeat (3) @(negedge clk);
  endtask

  function automatic logic [31:0] all_outs();
    return {spawn, eaten, randx, randy, mode, pack_live,
            fx_p1_active, fx_p2_active, fx_p1_mode, fx_p2_mode};
  endfunction

  initial begin
    enable = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("reset_outputs", all_outs(), 32'd0);
    reset = 1'b1;

    // first spawn after two ticks
    sb.push_back(EV_SPAWN);
    do_tick();
    check_eq("idle_after_1_tick", 32'(pack_live), 32'd0);
    do_tick();
    check_eq("live_after_spawn_tick", 32'(pack_live), 32'd1);

    // uneaten pack withdrawn on the third tick
    sb.push_back(EV_WITHDRAW);
    repeat (3) do_tick();
    check_eq("withdraw_p1_idle", 32'(fx_p1_active), 32'd0);
    check_eq("withdraw_p2_idle", 32'(fx_p2_active), 32'd0);
    sb.push_back(EV_SPAWN);
    repeat (2) do_tick();

    // single eat by P2, effect lasts two ticks
    sb.push_back(EV_GRANT2);
    do_eat(1'b0, 1'b1);
    check_eq("p2_only_p1_off", 32'(fx_p1_active), 32'd0);
    sb.push_back(EV_SPAWN);
    do_tick();
    check_eq("p2_fx_after_1_tick", 32'(fx_p2_active), 32'd1);
    do_tick();
    check_eq("p2_fx_cleared", 32'(fx_p2_active), 32'd0);
    check_eq("p2_mode_cleared", 32'(fx_p2_mode), 32'd0);

    // ties: pointer starts at P1, then toggles to P2
    sb.push_back(EV_GRANT1);
    do_eat(1'b1, 1'b1);
    check_eq("tie1_p2_off", 32'(fx_p2_active), 32'd0);
    sb.push_back(EV_SPAWN);
    repeat (2) do_tick();
    check_eq("tie1_p1_expired", 32'(fx_p1_active), 32'd0);
    sb.push_back(EV_GRANT2);
    do_eat(1'b1, 1'b1);
    check_eq("tie2_p1_off", 32'(fx_p1_active), 32'd0);

    // eat outside LIVE is ignored; enable=0 freezes counters
    do_eat(1'b1, 1'b0);
    check_eq("idle_eat_ignored", 32'(fx_p1_active), 32'd0);
    enable = 1'b0;
    repeat (3) do_tick();
    check_eq("frozen_fx_held", 32'(fx_p2_active), 32'd1);
    check_eq("frozen_no_live", 32'(pack_live), 32'd0);
    enable = 1'b1;
    sb.push_back(EV_SPAWN);
    do_tick();
    check_eq("resume_fx_held", 32'(fx_p2_active), 32'd1);
    check_eq("resume_no_live", 32'(pack_live), 32'd0);
    do_tick();
    check_eq("resume_fx_cleared", 32'(fx_p2_active), 32'd0);
    check_eq("resume_live", 32'(pack_live), 32'd1);

    // asynchronous reset with a P1 effect running
    sb.push_back(EV_GRANT1);
    do_eat(1'b1, 1'b0);
    check_eq("pre_reset_p1_on", 32'(fx_p1_active), 32'd1);
    @(negedge clk);
    #2 reset = 1'b0;
    #1 check_eq("async_reset_outputs", all_outs(), 32'd0);
    sb.delete();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    sb.push_back(EV_SPAWN);
    do_tick();
    check_eq("post_reset_idle", 32'(pack_live), 32'd0);
    do_tick();
    check_eq("post_reset_live", 32'(pack_live), 32'd1);

    repeat (4) @(negedge clk);
    check_eq("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
